// File: rtl/seq_detect.sv
// Serial pattern detector: tracks the longest matched prefix of PATTERN with full fallback.
// Optional lock on first match when SEQ_DETECT_LOCK_EN is defined.
module seq_detect #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       clear,
  input  logic                       valid,
  input  logic                       data,
  input  logic                       overlap,
  output logic                       match,
  output logic [$clog2(PAT_W+1)-1:0] progress,
  output logic [CNT_W-1:0]           hit_count,
  output logic                       locked
);

  localparam int SW = $clog2(PAT_W+1);

  // Longest j such that the tail of (prefix kp, then bit b) equals the first j pattern bits.
  function automatic int next_len(input int kp, input int b);
    logic [PAT_W-1:0] pat;
    int               n;
    int               best;
    int               idx;
    logic             sb;
    logic             ok;
    pat  = PATTERN;
    n    = kp + 1;
    best = 0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= n) begin
        ok = 1'b1;
        for (int m = 0; m < PAT_W; m++) begin
          if (m < j) begin
            idx = n - j + m;
            if (idx == kp) sb = b[0];
            else           sb = pat[PAT_W-1-idx];
            if (sb != pat[PAT_W-1-m]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] nxt_tbl [PAT_W+1][2];

  for (genvar kp = 0; kp <= PAT_W; kp++) begin : g_k
    for (genvar b = 0; b < 2; b++) begin : g_b
      localparam int NX = next_len(kp, b);
      assign nxt_tbl[kp][b] = SW'(NX);
    end
  end

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic [SW-1:0] src;
  logic [SW-1:0] cand;
  logic          adv;
  logic          enter;
  logic          frozen;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)     state <= '0;
    else if (clear) state <= '0;
    else            state <= state_nxt;
  end

  // A full match either continues as the whole pattern (overlap) or restarts from empty.
  always_comb begin
    src = state;
    if (state == SW'(PAT_W)) src = overlap ? SW'(PAT_W) : '0;
    cand      = nxt_tbl[src][data];
    adv       = valid && !frozen;
    state_nxt = adv ? cand : state;
    enter     = adv && (cand == SW'(PAT_W));
  end

  always_comb begin
    match    = (state == SW'(PAT_W));
    progress = state;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                           hit_count <= '0;
    else if (clear)                       hit_count <= '0;
    else if (enter && (hit_count != '1))  hit_count <= hit_count + 1'b1;
  end

`ifdef SEQ_DETECT_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)     lock_q <= 1'b0;
    else if (clear) lock_q <= 1'b0;
    else if (enter) lock_q <= 1'b1;
  end

  assign frozen = lock_q;
  assign locked = lock_q;
`else
  assign frozen = 1'b0;
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect.sv
// Randomized plus directed bench for seq_detect against a history-based reference model.
module tb_seq_detect;

  localparam int         PAT_W   = 4;
  localparam logic [3:0] PATTERN = 4'b1101;
  localparam int         CNT_W   = 2;
  localparam int         SW      = $clog2(PAT_W+1);
  localparam int         CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             arstn;
  logic             clear;
  logic             valid;
  logic             data;
  logic             overlap;
  logic             match;
  logic [SW-1:0]    progress;
  logic [CNT_W-1:0] hit_count;
  logic             locked;

  seq_detect #(.PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .clear     (clear),
    .valid     (valid),
    .data      (data),
    .overlap   (overlap),
    .match     (match),
    .progress  (progress),
    .hit_count (hit_count),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int prog;
    int m;
    int cnt;
    int lk;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  bit hist[$];
  bit m_lock;
  int m_cnt;
  int m_k;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Longest tail of the consumed history that equals a pattern prefix.
  function automatic int lps();
    logic [PAT_W-1:0] pat;
    int               n;
    int               best;
    bit               ok;
    pat  = PATTERN;
    n    = hist.size();
    best = 0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= n) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++)
          if (hist[n-j+m] != pat[PAT_W-1-m]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_lock = 1'b0;
    m_cnt  = 0;
    m_k    = 0;
  endtask

  task automatic step(input bit c, input bit v, input bit d, input bit ov);
    exp_t e;
    @(posedge clk);
    #2;
    clear   = c;
    valid   = v;
    data    = d;
    overlap = ov;
    if (c) model_reset();
    else if (v && !m_lock) begin
      if (m_k == PAT_W && !ov) hist.delete();
      hist.push_back(d);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      m_k = lps();
      if (m_k == PAT_W) begin
        if (m_cnt < CMAX) m_cnt++;
`ifdef SEQ_DETECT_LOCK_EN
        m_lock = 1'b1;
`endif
      end
    end
    e.prog = m_k;
    e.m    = (m_k == PAT_W) ? 1 : 0;
    e.cnt  = m_cnt;
    e.lk   = m_lock ? 1 : 0;
    sb_q.push_back(e);
  endtask

  task automatic play(input logic [15:0] bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], ov);
  endtask

  task automatic arst_pulse();
    @(posedge clk);
    #3;
    arstn = 1'b0;
    #1;
    chk("arst_progress", progress, 0);
    chk("arst_match", match, 0);
    chk("arst_hit_count", hit_count, 0);
    chk("arst_locked", locked, 0);
    model_reset();
    #2;
    arstn = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("progress", progress, e.prog);
        chk("match", match, e.m);
        chk("hit_count", hit_count, e.cnt);
        chk("locked", locked, e.lk);
      end
    end
  end

  initial begin : stim
    int r;
    clear   = 1'b0;
    valid   = 1'b0;
    data    = 1'b0;
    overlap = 1'b0;
    arstn   = 1'b0;
    model_reset();
    #1;
    chk("reset_progress", progress, 0);
    chk("reset_match", match, 0);
    chk("reset_hit_count", hit_count, 0);
    chk("reset_locked", locked, 0);
    #11;
    arstn = 1'b1;

    play(16'b1101, 4, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    play(16'b11101, 5, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    play(16'b1101101, 7, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    play(16'b1101101, 7, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Pattern with idle gaps carrying garbage data.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    play(16'b1101110111011101, 16, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);

    play(16'b110, 3, 1'b1);
    arst_pulse();
    step(1'b0, 1'b1, 1'b1, 1'b1);

    repeat (800) begin
      r = $urandom_range(0, 99);
      if (r == 0) arst_pulse();
      else step(r < 3, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 1) != 0);
    end

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
